mem_milestone_checker: RTL and testbench
========================================

Name: mem_milestone_checker

Overview:
Synthesizable, parametrised bus monitor for CPU bring-up benches and FPGA self-test. It watches the core's data-memory write port (memwrite/dataaddr/writedata) against a programmed table of NUM_EVENTS expected stores. It enforces a cycle budget and reports pass/fail with a cause code, replacing ad-hoc single-address checks in per-instruction testbenches. It sits beside the cpu instance and taps its memory-write outputs.

Parameters:
NUM_EVENTS, 4, number of expected store milestones (>=1)
ADDR_W, 32, dataaddr width
DATA_W, 32, writedata width
CNT_W, 16, cycle counter width
TIMEOUT_CYCLES, 22, RUN cycles allowed before timeout (1..2^CNT_W-1)
ORDERED, 1, 1 = events must hit in table order; 0 = any order

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
cfg_we  in  1  write one table entry
cfg_idx  in  IDX_W=max(1,$clog2(NUM_EVENTS))  entry index
cfg_addr  in  ADDR_W  expected store address
cfg_data  in  DATA_W  expected store data
start  in  1  begin checking run
memwrite  in  1  CPU store strobe
dataaddr  in  ADDR_W  CPU store address
writedata  in  DATA_W  CPU store data
busy  out  1  in RUN
done  out  1  run finished (sticky)
pass  out  1  run finished successfully (sticky)
fail_code  out  2  0 none, 1 bad data, 2 timeout, 3 order violation
hit_mask  out  NUM_EVENTS  bit i set once event i matched
hit_pulse  out  1  one-cycle pulse on each new match
cycle_cnt  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset: state IDLE; busy=0, done=0, pass=0, fail_code=0, hit_mask=0, hit_pulse=0, cycle_cnt=0. Event table cleared to addr=0, data=0. Reset mid-RUN aborts the run immediately with no done/pass.
- States: IDLE, RUN, PASS, FAIL.
- Config: cfg_we is honoured in IDLE, PASS and FAIL. It is ignored in RUN. cfg_idx >= NUM_EVENTS is ignored.
- start in IDLE/PASS/FAIL: next cycle enters RUN. It clears hit_mask, done, pass, fail_code and cycle_cnt, and sets next-expected index nxt=0. start in RUN is ignored. cfg_we and start in the same cycle: the table write lands first, and the run uses the new entry.
- RUN, each cycle: cycle_cnt += 1. The bus is sampled combinationally at the edge; no registering of CPU signals.
- Match, ORDERED=1: memwrite && dataaddr==addr[nxt]:
  - writedata==data[nxt] → set hit_mask[nxt], hit_pulse=1, nxt+=1.
  - Otherwise → FAIL, code 1.
- Order violation, ORDERED=1: memwrite && dataaddr equals the address of an unhit entry j>nxt, and dataaddr!=addr[nxt] → FAIL, code 3.
- Match, ORDERED=0: the lowest-index unhit entry with matching address is considered.
  - Data equal → hit.
  - Data unequal → FAIL, code 1.
  - Entries already hit are ignored, so a repeat store to them is harmless.
- Stores to addresses not in the table are ignored.
- All entries hit → PASS next cycle: done=1, pass=1, busy=0.
- Timeout: if, at the edge where cycle_cnt would become TIMEOUT_CYCLES, not all entries are hit → FAIL, code 2.
- Simultaneous final match and timeout → PASS wins.
- Simultaneous data-mismatch and timeout → code 1.
- FAIL: done=1, pass=0, busy=0. fail_code holds its cause until next start or reset.
- Sticky outputs: cycle_cnt freezes on exit from RUN. hit_mask holds on exit from RUN.
- hit_pulse is high only in the cycle after a match edge.
- Duplicate table addresses:
  - ORDERED=1: entries are consumed in turn.
  - ORDERED=0: the lowest unhit entry wins.

Test Plan:
- NUM_EVENTS=2, ORDERED=1, table {0:(80,1), 1:(84,2)}, start; store 80←1 at cycle 4, 84←2 at cycle 9 → hit_pulse at cycles 5 and 10, pass=1 and done=1 at cycle 10, fail_code=0, cycle_cnt=9.
- Same table; store 80←7 → FAIL, fail_code=1, hit_mask=00, pass=0.
- Same table; store 84←2 first → FAIL, fail_code=3. Repeat with ORDERED=0 → hit_mask=10, then 80←1 → PASS.
- Same table, TIMEOUT_CYCLES=22, only 80←1 issued → FAIL at cycle_cnt=22, fail_code=2, hit_mask=01. Final store landing exactly on cycle 22 → PASS.
- Reset asserted mid-RUN after one hit → all outputs 0 next cycle, table cleared. Restart with an empty table and a store 0←0 → PASS.
- cfg_we pulse during RUN to entry 0 → table unchanged; start pulse during RUN → cycle_cnt not cleared.

Source files
------------

// File: rtl/mem_milestone_checker.sv
// Bus monitor that checks a CPU's data-memory stores against a programmed table
// of expected (address, data) milestones within a cycle budget.
module mem_milestone_checker #(
   parameter int NUM_EVENTS     = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 22,
   parameter bit ORDERED        = 1'b1,
   localparam int IDX_W         = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_we,
   input  logic [IDX_W-1:0]      cfg_idx,
   input  logic [ADDR_W-1:0]     cfg_addr,
   input  logic [DATA_W-1:0]     cfg_data,
   input  logic                  start,
   input  logic                  memwrite,
   input  logic [ADDR_W-1:0]     dataaddr,
   input  logic [DATA_W-1:0]     writedata,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [1:0]            fail_code,
   output logic [NUM_EVENTS-1:0] hit_mask,
   output logic                  hit_pulse,
   output logic [CNT_W-1:0]      cycle_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   localparam logic [1:0] CODE_DATA    = 2'd1;
   localparam logic [1:0] CODE_TIMEOUT = 2'd2;
   localparam logic [1:0] CODE_ORDER   = 2'd3;

   state_t              state;
   logic [IDX_W-1:0]    nxt;
   logic [ADDR_W-1:0]   ev_addr [NUM_EVENTS];
   logic [DATA_W-1:0]   ev_data [NUM_EVENTS];

   logic                  match_hit;
   logic                  match_bad;
   logic                  order_bad;
   logic                  found;
   logic [IDX_W-1:0]      match_idx;
   logic [NUM_EVENTS-1:0] new_mask;

   // Match resolution works directly on the live bus so a store counts on the edge it is presented.
   always_comb begin
      match_hit = 1'b0;
      match_bad = 1'b0;
      order_bad = 1'b0;
      found     = 1'b0;
      match_idx = '0;
      if (ORDERED) begin
         if (memwrite && dataaddr == ev_addr[nxt]) begin
            match_idx = nxt;
            match_hit = (writedata == ev_data[nxt]);
            match_bad = (writedata != ev_data[nxt]);
         end else if (memwrite) begin
            for (int j = 0; j < NUM_EVENTS; j++)
               if (j > int'(nxt) && !hit_mask[j] && dataaddr == ev_addr[j])
                  order_bad = 1'b1;
         end
      end else begin
         for (int j = 0; j < NUM_EVENTS; j++) begin
            if (!found && memwrite && !hit_mask[j] && dataaddr == ev_addr[j]) begin
               found     = 1'b1;
               match_idx = IDX_W'(j);
               match_hit = (writedata == ev_data[j]);
               match_bad = (writedata != ev_data[j]);
            end
         end
      end
      new_mask = hit_mask;
      if (match_hit)
         new_mask[match_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         nxt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_code <= '0;
         hit_mask  <= '0;
         hit_pulse <= 1'b0;
         cycle_cnt <= '0;
         // NOTE: the table is a small register file, not RAM, so clearing it on reset is cheap and required.
         for (int i = 0; i < NUM_EVENTS; i++) begin
            ev_addr[i] <= '0;
            ev_data[i] <= '0;
         end
      end else begin
         hit_pulse <= 1'b0;
         if (cfg_we && state != S_RUN && 32'(cfg_idx) < NUM_EVENTS) begin
            ev_addr[cfg_idx] <= cfg_addr;
            ev_data[cfg_idx] <= cfg_data;
         end
         case (state)
            S_RUN: begin
               cycle_cnt <= cycle_cnt + 1'b1;
               hit_mask  <= new_mask;
               if (match_hit) begin
                  hit_pulse <= 1'b1;
                  nxt       <= nxt + 1'b1;
               end
               // Final hit beats timeout; a bus fault beats timeout.
               if (&new_mask) begin
                  state <= S_PASS;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= 1'b1;
               end else if (match_bad || order_bad || cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state     <= S_FAIL;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  fail_code <= match_bad ? CODE_DATA : (order_bad ? CODE_ORDER : CODE_TIMEOUT);
               end
            end
            default: begin
               if (start) begin
                  state     <= S_RUN;
                  nxt       <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  fail_code <= '0;
                  hit_mask  <= '0;
                  cycle_cnt <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_milestone_checker.sv
// Directed bench: an ordered and an unordered checker share one stimulus stream.
module tb_mem_milestone_checker;

   logic        clk = 1'b0;
   logic        reset, cfg_we, start, memwrite;
   logic [0:0]  cfg_idx;
   logic [31:0] cfg_addr, cfg_data, dataaddr, writedata;

   logic        u1_busy, u1_done, u1_pass, u1_hit_pulse;
   logic [1:0]  u1_fail_code, u1_hit_mask;
   logic [15:0] u1_cycle_cnt;
   logic        u0_busy, u0_done, u0_pass, u0_hit_pulse;
   logic [1:0]  u0_fail_code, u0_hit_mask;
   logic [15:0] u0_cycle_cnt;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   mem_milestone_checker #(.NUM_EVENTS(2), .TIMEOUT_CYCLES(22), .ORDERED(1'b1)) u_ord (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .start(start), .memwrite(memwrite), .dataaddr(dataaddr),
      .writedata(writedata), .busy(u1_busy), .done(u1_done), .pass(u1_pass),
      .fail_code(u1_fail_code), .hit_mask(u1_hit_mask), .hit_pulse(u1_hit_pulse),
      .cycle_cnt(u1_cycle_cnt));

   mem_milestone_checker #(.NUM_EVENTS(2), .TIMEOUT_CYCLES(22), .ORDERED(1'b0)) u_any (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .start(start), .memwrite(memwrite), .dataaddr(dataaddr),
      .writedata(writedata), .busy(u0_busy), .done(u0_done), .pass(u0_pass),
      .fail_code(u0_fail_code), .hit_mask(u0_hit_mask), .hit_pulse(u0_hit_pulse),
      .cycle_cnt(u0_cycle_cnt));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg(input logic [0:0] idx, input logic [31:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1; dataaddr = a; writedata = d;
      tick();
      memwrite = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cfg_we = 1'b0; start = 1'b0; memwrite = 1'b0;
      cfg_idx = '0; cfg_addr = '0; cfg_data = '0; dataaddr = '0; writedata = '0;
      tick(2);
      reset = 1'b0;
      check("rst_busy", 32'(u1_busy), 32'd0);
      check("rst_done_pass", {u1_done, u1_pass}, 32'd0);
      check("rst_code_mask", {u1_fail_code, u1_hit_mask}, 32'd0);
      check("rst_cnt", 32'(u1_cycle_cnt), 32'd0);

      cfg(1'b0, 32'd80, 32'd1);
      cfg(1'b1, 32'd84, 32'd2);

      // In-order pass: stores land on cycles 4 and 9
      go();
      check("run_busy", 32'(u1_busy), 32'd1);
      tick(3);
      store(32'd80, 32'd1);
      check("p1_pulse", 32'(u1_hit_pulse), 32'd1);
      check("p1_mask", 32'(u1_hit_mask), 32'b01);
      check("p1_cnt", 32'(u1_cycle_cnt), 32'd4);
      tick();
      check("p1_pulse_drop", 32'(u1_hit_pulse), 32'd0);
      tick(3);
      store(32'd84, 32'd2);
      check("p2_pulse", 32'(u1_hit_pulse), 32'd1);
      check("p2_done_pass_busy", {u1_done, u1_pass, u1_busy}, 32'b110);
      check("p2_code", 32'(u1_fail_code), 32'd0);
      check("p2_cnt", 32'(u1_cycle_cnt), 32'd9);
      tick(2);
      check("p2_cnt_frozen", 32'(u1_cycle_cnt), 32'd9);
      check("p2_mask_held", 32'(u1_hit_mask), 32'b11);

      // Bad data on the expected address
      go();
      store(32'd80, 32'd7);
      check("bad_code", 32'(u1_fail_code), 32'd1);
      check("bad_mask", 32'(u1_hit_mask), 32'b00);
      check("bad_done_pass", {u1_done, u1_pass}, 32'b10);
      check("bad_code_any", 32'(u0_fail_code), 32'd1);

      // Out-of-order store: ordered fails, unordered accepts
      go();
      check("restart_clear", {u1_done, u1_fail_code}, 32'd0);
      store(32'd84, 32'd2);
      check("ord_code", 32'(u1_fail_code), 32'd3);
      check("any_mask", 32'(u0_hit_mask), 32'b10);
      check("any_busy", 32'(u0_busy), 32'd1);
      store(32'd80, 32'd1);
      check("any_pass", {u0_done, u0_pass}, 32'b11);
      check("ord_code_held", 32'(u1_fail_code), 32'd3);

      // Timeout with only the first milestone hit
      go();
      store(32'd80, 32'd1);
      tick(20);
      check("to_pre_busy", 32'(u1_busy), 32'd1);
      tick();
      check("to_code", 32'(u1_fail_code), 32'd2);
      check("to_cnt", 32'(u1_cycle_cnt), 32'd22);
      check("to_mask", 32'(u1_hit_mask), 32'b01);
      check("to_done_pass", {u1_done, u1_pass}, 32'b10);

      // Final store on the timeout edge wins
      go();
      store(32'd80, 32'd1);
      tick(20);
      store(32'd84, 32'd2);
      check("edge_pass", {u1_done, u1_pass, u1_fail_code}, 32'b1100);
      check("edge_cnt", 32'(u1_cycle_cnt), 32'd22);

      // Config writes and start pulses are ignored while running
      go();
      cfg(1'b0, 32'd200, 32'd9);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("run_start_ign_cnt", 32'(u1_cycle_cnt), 32'd2);
      store(32'd80, 32'd1);
      check("run_cfg_ign_mask", 32'(u1_hit_mask), 32'b01);
      store(32'd84, 32'd2);
      check("run_cfg_ign_pass", 32'(u1_pass), 32'd1);

      // Reset mid-run clears outputs and the table
      go();
      store(32'd80, 32'd1);
      check("mid_mask", 32'(u1_hit_mask), 32'b01);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_flags", {u1_busy, u1_done, u1_pass, u1_hit_pulse}, 32'd0);
      check("mid_rst_code_mask", {u1_fail_code, u1_hit_mask}, 32'd0);
      check("mid_rst_cnt", 32'(u1_cycle_cnt), 32'd0);
      go();
      store(32'd80, 32'd1);
      check("cleared_no_hit", {u1_hit_mask, u1_fail_code, u1_busy}, 32'b00001);
      memwrite = 1'b1; dataaddr = 32'd0; writedata = 32'd0;
      tick();
      check("zero_hit0", 32'(u1_hit_mask), 32'b01);
      tick();
      memwrite = 1'b0;
      check("zero_pass", {u1_done, u1_pass}, 32'b11);
      check("zero_pass_any", {u0_done, u0_pass}, 32'b11);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
